// File: rtl/result_bram_reader_pkg.sv
// Shared types and constants for the result BRAM drain path.
package result_bram_reader_pkg;

  localparam int unsigned DefWidth     = 16;
  localparam int unsigned DefChunkSize = 4;
  localparam int unsigned DefWordWidth = DefWidth * DefChunkSize;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } state_e;

  // Result words per pass for an I x W output tiled into BLOCK_SIZE-wide chunks.
  function automatic int unsigned calc_num_words(input int unsigned i_outer_dimension,
                                                 input int unsigned w_outer_dimension,
                                                 input int unsigned block_size);
    return ((i_outer_dimension + block_size - 1) / block_size) *
           ((w_outer_dimension + block_size - 1) / block_size);
  endfunction

endpackage

// File: rtl/result_bram_reader_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; head is visible while not empty.
module result_bram_reader_sync_fifo #(
  parameter int unsigned Width = 65,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       valid_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    valid_o  = (count_q != '0);
    do_pop   = pop_i & valid_o;
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CntW'(push_i) - CntW'(do_pop);
    data_o   = valid_o ? mem_q[rd_ptr_q] : '0;
    count_o  = count_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Upstream credit accounting must never let a write land on a full FIFO.
  write_when_full_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_i && (count_q == CntW'(Depth))));

endmodule

// File: rtl/result_bram_reader.sv
// Drains the result BRAM over port B and streams the words out with valid/ready/last.
module result_bram_reader
  import result_bram_reader_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned CHUNK_SIZE = DefChunkSize,
  parameter int unsigned NUM_WORDS  = 9,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        bram_enb,
  output logic [ADDR_WIDTH-1:0]       bram_addrb,
  input  logic [WIDTH*CHUNK_SIZE-1:0] bram_doutb,
  output logic [WIDTH*CHUNK_SIZE-1:0] m_data,
  output logic                        m_valid,
  output logic                        m_last,
  input  logic                        m_ready
);
  localparam int unsigned WordW = WIDTH * CHUNK_SIZE;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_WORDS - 1);

  state_e                state_q, state_d;
  logic                  busy_q, busy_d, done_q, done_d, enb_q, enb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, rd_cnt_q, rd_cnt_d;
  logic [RD_LATENCY-1:0] sr_valid_q, sr_valid_d, sr_last_q, sr_last_d;
  logic [CntW-1:0]       fifo_count;
  logic                  pop, can_issue;
  int unsigned           outstanding;

  assign pop        = m_valid & m_ready;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bram_enb   = enb_q;
  assign bram_addrb = addr_q;

  // Every read already issued owns a FIFO slot; a word popped this cycle frees its slot.
  always_comb begin
    outstanding = 32'(fifo_count) + 32'(enb_q) - 32'(pop);
    for (int unsigned i = 0; i < RD_LATENCY; i++) outstanding += 32'(sr_valid_q[i]);
    can_issue = (outstanding + 1) <= FIFO_DEPTH;
  end

  // Stage 0 lines up with the cycle after enb; the top stage lines up with valid doutb.
  always_comb begin
    sr_valid_d[0] = enb_q;
    sr_last_d[0]  = enb_q & (addr_q == LastAddr);
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      sr_valid_d[i] = sr_valid_q[i-1];
      sr_last_d[i]  = sr_last_q[i-1];
    end
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    enb_d    = 1'b0;
    addr_d   = addr_q;
    rd_cnt_d = rd_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRead;
          busy_d   = 1'b1;
          rd_cnt_d = '0;
        end
      end
      StRead: begin
        if (can_issue) begin
          enb_d    = 1'b1;
          addr_d   = rd_cnt_q;
          rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
          if (rd_cnt_q == LastAddr) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && m_last) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      enb_q      <= 1'b0;
      addr_q     <= '0;
      rd_cnt_q   <= '0;
      sr_valid_q <= '0;
      sr_last_q  <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      enb_q      <= enb_d;
      addr_q     <= addr_d;
      rd_cnt_q   <= rd_cnt_d;
      sr_valid_q <= sr_valid_d;
      sr_last_q  <= sr_last_d;
    end
  end

  result_bram_reader_sync_fifo #(
    .Width(WordW + 1),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (sr_valid_q[RD_LATENCY-1]),
    .data_i ({sr_last_q[RD_LATENCY-1], bram_doutb}),
    .pop_i  (pop),
    .data_o ({m_last, m_data}),
    .valid_o(m_valid),
    .count_o(fifo_count)
  );

endmodule

// File: tb/tb_result_bram_reader.sv
// Directed bench: main instance (latency 2) plus latency-1 and latency-4 instances.
module tb_result_bram_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start, ready, enb, mv, ml, busy, done;
  logic [13:0] addr [3];
  logic [63:0] dout [3];
  logic [63:0] md   [3];
  logic [3:0]  pv   [3];
  logic [13:0] pa   [3][4];
  localparam int Lat [3] = '{2, 1, 4};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] word(input int i);
    logic [15:0] e;
    e = 16'h0100 + 16'(i);
    return {4{e}};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  result_bram_reader #(.RD_LATENCY(2), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .bram_enb(enb[0]), .bram_addrb(addr[0]), .bram_doutb(dout[0]),
    .m_data(md[0]), .m_valid(mv[0]), .m_last(ml[0]), .m_ready(ready[0])
  );
  result_bram_reader #(.RD_LATENCY(1), .FIFO_DEPTH(4)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .bram_enb(enb[1]), .bram_addrb(addr[1]), .bram_doutb(dout[1]),
    .m_data(md[1]), .m_valid(mv[1]), .m_last(ml[1]), .m_ready(ready[1])
  );
  result_bram_reader #(.RD_LATENCY(4), .FIFO_DEPTH(6)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .bram_enb(enb[2]), .bram_addrb(addr[2]), .bram_doutb(dout[2]),
    .m_data(md[2]), .m_valid(mv[2]), .m_last(ml[2]), .m_ready(ready[2])
  );

  // BRAM models: data valid Lat cycles after the enb cycle, garbage otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      pv[k]    <= rst_n ? {pv[k][2:0], enb[k]} : 4'd0;
      pa[k][0] <= addr[k];
      for (int s = 1; s < 4; s++) pa[k][s] <= pa[k][s-1];
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      dout[k] = pv[k][Lat[k]-1] ? word(32'(pa[k][Lat[k]-1])) : 64'hdead_beef_dead_beef;
    end
  end

  // Monitor for the main instance, sampled on the falling edge.
  int          t_start, first_v, done_c, done_cnt, acc, issued, last_acc_c;
  int          first_enb_c, last_enb_c;
  logic        busy_at_done, prev_stall, prev_last;
  logic [63:0] prev_data;

  task automatic clear_mon();
    t_start = 0; first_v = -1; done_c = -1; done_cnt = 0; acc = 0; issued = 0;
    last_acc_c = -1; first_enb_c = -1; last_enb_c = -1;
    busy_at_done = 1'b1; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (start[0] && !busy[0]) t_start = cyc + 1;
      if (mv[0] && first_v < 0) first_v = cyc;
      if (enb[0]) begin
        check_eq("addr", 64'(addr[0]), 64'(issued));
        issued++;
        check_eq("credit", 64'(issued - acc <= 4), 64'd1);
        if (first_enb_c < 0) first_enb_c = cyc;
        last_enb_c = cyc;
      end
      if (prev_stall) begin
        check_eq("hold_valid", 64'(mv[0]), 64'd1);
        check_eq("hold_data", md[0], prev_data);
        check_eq("hold_last", 64'(ml[0]), 64'(prev_last));
      end
      if (mv[0] && ready[0]) begin
        check_eq("data", md[0], word(acc));
        check_eq("last", 64'(ml[0]), 64'(acc == 8));
        acc++;
        last_acc_c = cyc;
      end
      prev_stall = mv[0] && !ready[0];
      prev_data  = md[0];
      prev_last  = ml[0];
      if (done[0]) begin
        done_cnt++;
        done_c       = cyc;
        busy_at_done = busy[0];
      end
    end
  end

  // mode 0: ready high; 1: 1,0,0,1 pattern; 2: stalled 20 cycles; 3: extra start mid-pass.
  task automatic run_until_done(input int mode, input int budget);
    int i;
    i = 0;
    while (done_cnt == 0 && i < budget) begin
      case (mode)
        1:       ready[0] = (i % 4 == 0) || (i % 4 == 3);
        2:       ready[0] = (i >= 20);
        default: ready[0] = 1'b1;
      endcase
      start[0] = (mode == 3) && (i == 5);
      if (mode == 2 && i == 20) begin
        check_eq("stall_reads", 64'(issued), 64'd4);
        check_eq("stall_valid", 64'(mv[0]), 64'd1);
        check_eq("stall_data", md[0], word(0));
        check_eq("stall_enb", 64'(enb[0]), 64'd0);
      end
      tick();
      i++;
    end
    start[0] = 1'b0;
    ready[0] = 1'b1;
    check_eq("pass_done_seen", 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic pulse_start0();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
  endtask

  int fv [3];
  int nw [3];
  int nd [3];
  int t_sw;
  int w;

  initial begin
    rst_n = 1'b0;
    start = '0;
    ready = 3'b111;
    clear_mon();
    repeat (3) tick();
    check_eq("rst_busy", 64'(busy[0]), 64'd0);
    check_eq("rst_done", 64'(done[0]), 64'd0);
    check_eq("rst_enb", 64'(enb[0]), 64'd0);
    check_eq("rst_addr", 64'(addr[0]), 64'd0);
    check_eq("rst_valid", 64'(mv[0]), 64'd0);
    check_eq("rst_last", 64'(ml[0]), 64'd0);
    check_eq("rst_data", md[0], 64'd0);
    rst_n = 1'b1;
    tick();

    // Latency sweep on the latency-1 and latency-4 instances.
    for (int k = 0; k < 3; k++) begin
      fv[k] = -1; nw[k] = 0; nd[k] = 0;
    end
    start[2:1] = 2'b11;
    t_sw = cyc + 1;
    tick();
    start[2:1] = 2'b00;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      for (int k = 1; k < 3; k++) begin
        if (mv[k]) begin
          if (fv[k] < 0) fv[k] = cyc - t_sw;
          check_eq("lat_data", md[k], word(nw[k]));
          check_eq("lat_last", 64'(ml[k]), 64'(nw[k] == 8));
          nw[k]++;
        end
        if (done[k]) nd[k]++;
      end
    end
    check_eq("lat1_first_valid", 64'(fv[1]), 64'd3);
    check_eq("lat4_first_valid", 64'(fv[2]), 64'd6);
    check_eq("lat1_words", 64'(nw[1]), 64'd9);
    check_eq("lat4_words", 64'(nw[2]), 64'd9);
    check_eq("lat1_done", 64'(nd[1]), 64'd1);
    check_eq("lat4_done", 64'(nd[2]), 64'd1);
    tick();

    // Free-running drain.
    clear_mon();
    pulse_start0();
    run_until_done(0, 60);
    repeat (3) tick();
    check_eq("free_first_valid", 64'(first_v - t_start), 64'd4);
    check_eq("free_last_accept", 64'(last_acc_c - t_start), 64'd12);
    check_eq("free_done_cycle", 64'(done_c - t_start), 64'd13);
    check_eq("free_busy_at_done", 64'(busy_at_done), 64'd0);
    check_eq("free_words", 64'(acc), 64'd9);
    check_eq("free_done_count", 64'(done_cnt), 64'd1);

    // Backpressure 1,0,0,1.
    clear_mon();
    pulse_start0();
    run_until_done(1, 120);
    repeat (3) tick();
    check_eq("bp_words", 64'(acc), 64'd9);
    check_eq("bp_done_count", 64'(done_cnt), 64'd1);
    check_eq("bp_enb_gaps", 64'((last_enb_c - first_enb_c + 1) > 9), 64'd1);

    // Full stall then release.
    clear_mon();
    pulse_start0();
    run_until_done(2, 120);
    repeat (3) tick();
    check_eq("stall_words", 64'(acc), 64'd9);
    check_eq("stall_done_count", 64'(done_cnt), 64'd1);

    // Start while busy.
    clear_mon();
    pulse_start0();
    run_until_done(3, 60);
    repeat (5) tick();
    check_eq("sb_words", 64'(acc), 64'd9);
    check_eq("sb_done_count", 64'(done_cnt), 64'd1);
    check_eq("sb_idle_after", 64'(busy[0]), 64'd0);
    check_eq("sb_reads", 64'(issued), 64'd9);

    // Reset mid-pass after five accepted words.
    clear_mon();
    pulse_start0();
    w = 0;
    while (acc < 5 && w < 40) begin
      tick();
      w++;
    end
    check_eq("mid_accepted", 64'(acc), 64'd5);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 64'(busy[0]), 64'd0);
    check_eq("mid_rst_enb", 64'(enb[0]), 64'd0);
    check_eq("mid_rst_addr", 64'(addr[0]), 64'd0);
    check_eq("mid_rst_valid", 64'(mv[0]), 64'd0);
    check_eq("mid_rst_data", md[0], 64'd0);
    check_eq("mid_rst_last", 64'(ml[0]), 64'd0);
    repeat (4) tick();
    check_eq("mid_no_done", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check_eq("mid_idle_after_rst", 64'(busy[0]), 64'd0);
    clear_mon();
    pulse_start0();
    run_until_done(0, 60);
    repeat (3) tick();
    check_eq("mid_rerun_words", 64'(acc), 64'd9);
    check_eq("mid_rerun_done", 64'(done_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/result_bram_reader.md
Name: result_bram_reader

Overview:
- Drains the result BRAM of the matrix-multiply top after a compute pass completes.
- Acts as the read-side counterpart to the port-A loaders that write the weight and input BRAMs.
- Issues sequential port-B reads of NUM_WORDS result chunks and absorbs the fixed BRAM read latency.
- Presents the chunks as a valid/ready stream with a last flag, tolerating arbitrary downstream backpressure without dropping or duplicating words.

Parameters:
- WIDTH, 16, bit width of one fixed-point element.
- CHUNK_SIZE, 4, elements per BRAM word; word width is WIDTH*CHUNK_SIZE.
- NUM_WORDS, 9, result words per pass (ROW_SIZE_MAT_C*COL_SIZE_MAT_C).
- ADDR_WIDTH, 14, port-B address width.
- RD_LATENCY, 2, BRAM port-B read latency in cycles (1..4).
- FIFO_DEPTH, 4, skid buffer depth; must be at least RD_LATENCY+2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a drain pass.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse after the last word is accepted downstream.
- bram_enb  output  1  port-B read enable.
- bram_addrb  output  ADDR_WIDTH  port-B read address.
- bram_doutb  input  WIDTH*CHUNK_SIZE  port-B read data, valid RD_LATENCY cycles after an enb cycle.
- m_data  output  WIDTH*CHUNK_SIZE  stream data.
- m_valid  output  1  stream data valid.
- m_last  output  1  marks word NUM_WORDS-1.
- m_ready  input  1  downstream accept.

Behaviour:
- Reset (async, rst_n=0) clears all registers and outputs:
  - busy, done, bram_enb, m_valid, m_last = 0; bram_addrb = 0; m_data = 0.
  - FIFO is emptied, the in-flight shift register is cleared, and the FSM returns to IDLE.
  - Reset mid-pass aborts the pass; no done is produced.
- FSM:
  - IDLE: on start=1, go to READ; busy=1 from the next cycle; read counter rd_cnt=0.
  - READ: issue a read (bram_enb=1, bram_addrb=rd_cnt, rd_cnt++) in any cycle where fifo_count + inflight + 1 <= FIFO_DEPTH (credit rule). Otherwise hold enb=0 and keep the address stable. After issuing address NUM_WORDS-1, go to DRAIN.
  - DRAIN: no reads. When the word tagged last is accepted (m_valid & m_ready & m_last), pulse done for one cycle and go to IDLE; busy drops in the same cycle done is high.
- start while busy is ignored and has no side effects.
- In-flight tracking: a RD_LATENCY-deep valid/last shift register. When it emits valid, bram_doutb is written to the FIFO tail with its last tag.
  - The credit rule guarantees no FIFO overflow; write-when-full is unreachable, and a verification assertion checks it.
- FIFO:
  - Show-ahead: m_valid = !empty; m_data and m_last come from the head.
  - Pop on m_valid & m_ready.
  - Simultaneous push and pop in the same cycle keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: with start sampled at rising edge t and m_ready held high:
  - First enb cycle is t+1.
  - First m_valid is cycle t+2+RD_LATENCY.
  - Sustained throughput is 1 word/cycle.
  - done occurs in the cycle after word NUM_WORDS-1 is accepted.
- m_data, m_valid, and m_last hold stable while m_valid=1 and m_ready=0 (AXI-stream rule).
- Addresses are 0..NUM_WORDS-1 in ascending order with no wrap within a pass. Each new pass restarts at 0.
- NUM_WORDS=1: the single word has m_last=1.

Decomposition:
- Shared package:
  - Word-width constant WIDTH*CHUNK_SIZE.
  - FSM state enum (IDLE, READ, DRAIN).
  - Helper function computing NUM_WORDS from I_OUTER_DIMENSION, W_OUTER_DIMENSION, and BLOCK_SIZE.
- One sub-module: sync_fifo, a parameterised show-ahead FIFO with data width, depth, and count output, storing {last, data}.

Test Plan:
- Free-running drain:
  - Stimulus: BRAM model preloaded with word[i] = {4{16'h0100+i}}, RD_LATENCY=2, m_ready=1, start pulse at t.
  - Required: 9 words in order on cycles t+4..t+12; m_last only on the 9th word; done at t+13; busy low from t+13.
- Backpressure:
  - Stimulus: m_ready toggles 1,0,0,1 repeating.
  - Required: all 9 words delivered exactly once, in order; data stable during stalls; fifo_count never exceeds 4; bram_enb deasserts while credits are exhausted.
- Full stall:
  - Stimulus: m_ready=0 for 20 cycles after start.
  - Required: exactly 4 reads issued (addresses 0..3), m_valid=1 holding word0. When m_ready rises, the remaining reads resume from address 4.
- Start while busy:
  - Stimulus: second start pulse mid-pass.
  - Required: ignored; exactly 9 words and one done.
- Reset mid-pass:
  - Stimulus: rst_n=0 after 5 words are accepted.
  - Required: all outputs 0 immediately and no done. A new start then reads from address 0 and delivers all 9 words.
- Latency sweep:
  - Stimulus: RD_LATENCY=1 and RD_LATENCY=4 (with FIFO_DEPTH=6).
  - Required: first m_valid at t+3 and t+6 respectively; words 0..8 delivered correctly.
